// File: rtl/audio_pkg.sv
// Shared audio-path definitions: receiver FSM encoding, I2S framing constant
// and the sample-format helpers used by the DSM feed.
package audio_pkg;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } rx_state_t;

  localparam int I2S_DELAY_BITS = 1;

  function automatic logic [63:0] midscale(input int width);
    return 64'd1 << (width - 1);
  endfunction

  // Two's complement to offset binary is just an MSB flip at the given width.
  function automatic logic [63:0] to_offset_bin(input logic [63:0] x, input int width);
    return x ^ (64'd1 << (width - 1));
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, followed by one register
// that holds the synced level and registered rise/fall strobes (all aligned).
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic aclr,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      sync_q <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      level  <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~level;
      fall   <= ~sync_q[SYNC_STAGES-1] & level;
    end
  end

endmodule

// File: rtl/i2s_rx_stereo.sv
// I2S slave receiver: oversamples BCLK/LRCLK/SDATA, deserialises both slots and
// presents an offset-binary stereo pair to the DSM once per legal frame.
//   state | meaning
//   SYNC  | waiting for a falling LRCLK edge to align to a frame
//   LEFT  | capturing the left slot
//   RIGHT | capturing the right slot; falling edge publishes the pair
module i2s_rx_stereo
  import audio_pkg::*;
#(
  parameter int DSM_WIDTH   = 16,
  parameter int MAX_SLOT    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 i2s_bclk,
  input  logic                 i2s_lrclk,
  input  logic                 i2s_sdata,
  output logic [DSM_WIDTH-1:0] left_pcm,
  output logic [DSM_WIDTH-1:0] right_pcm,
  output logic                 sample_valid,
  output logic                 frame_err
);

  localparam int CW = $clog2(MAX_SLOT + 2);
  localparam logic [CW-1:0] CNT_SAT   = CW'(MAX_SLOT + 1);
  localparam logic [CW-1:0] CNT_SLOT  = CW'(MAX_SLOT);
  localparam logic [CW-1:0] CNT_MIN   = CW'(DSM_WIDTH + I2S_DELAY_BITS);
  localparam logic [CW-1:0] CNT_FIRST = CW'(I2S_DELAY_BITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(I2S_DELAY_BITS + DSM_WIDTH - 1);
  localparam logic [DSM_WIDTH-1:0] MID = DSM_WIDTH'(midscale(DSM_WIDTH));

  logic bclk_rise, unused_bclk_lvl, unused_bclk_fall;
  logic lr_lvl, lr_rise, lr_fall, lr_edge;
  logic [SYNC_STAGES:0] sdata_q;
  logic sdata_s;

  rx_state_t state, state_nxt;
  logic [CW-1:0] bit_cnt;
  logic [DSM_WIDTH-1:0] sr_l, sr_r;
  logic slot_ok, overflow, shift_en, valid_nxt, err_nxt;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
    .clk(clk), .aclr(aclr), .din(i2s_bclk),
    .level(unused_bclk_lvl), .rise(bclk_rise), .fall(unused_bclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lr (
    .clk(clk), .aclr(aclr), .din(i2s_lrclk),
    .level(lr_lvl), .rise(lr_rise), .fall(lr_fall)
  );

  // One extra stage so data lines up with the registered BCLK strobe.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) sdata_q <= '0;
    else       sdata_q <= {sdata_q[SYNC_STAGES-1:0], i2s_sdata};
  end
  assign sdata_s = sdata_q[SYNC_STAGES];

  assign lr_edge  = lr_rise | lr_fall;
  assign slot_ok  = (bit_cnt >= CNT_MIN) && (bit_cnt <= CNT_SLOT);
  assign overflow = bclk_rise && !lr_edge && (bit_cnt == CNT_SLOT);
  assign shift_en = bclk_rise && !lr_edge && (bit_cnt >= CNT_FIRST) && (bit_cnt <= CNT_LAST);

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) state <= ST_SYNC;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_SYNC: begin
        if (lr_edge && !lr_lvl) state_nxt = ST_LEFT;
      end
      ST_LEFT: begin
        if (lr_edge) begin
          if (slot_ok && lr_lvl) begin
            state_nxt = ST_RIGHT;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = lr_lvl ? ST_SYNC : ST_LEFT;
          end
        end else if (overflow) begin
          err_nxt   = 1'b1;
          state_nxt = ST_SYNC;
        end
      end
      ST_RIGHT: begin
        if (lr_edge) begin
          if (slot_ok && !lr_lvl) begin
            state_nxt = ST_LEFT;
            valid_nxt = 1'b1;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = lr_lvl ? ST_SYNC : ST_LEFT;
          end
        end else if (overflow) begin
          err_nxt   = 1'b1;
          state_nxt = ST_SYNC;
        end
      end
      default: state_nxt = ST_SYNC;
    endcase
  end

  // A BCLK rise coincident with the LR edge is the new slot's delay bit.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr)                             bit_cnt <= '0;
    else if (lr_edge)                      bit_cnt <= bclk_rise ? CW'(1) : '0;
    else if (bclk_rise && bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      sr_l <= '0;
      sr_r <= '0;
    end else begin
      if (lr_edge && state_nxt == ST_LEFT)   sr_l <= '0;
      if (lr_edge && state_nxt == ST_RIGHT)  sr_r <= '0;
      if (shift_en && state == ST_LEFT)      sr_l <= {sr_l[DSM_WIDTH-2:0], sdata_s};
      if (shift_en && state == ST_RIGHT)     sr_r <= {sr_r[DSM_WIDTH-2:0], sdata_s};
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      left_pcm     <= MID;
      right_pcm    <= MID;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sample_valid <= valid_nxt;
      frame_err    <= err_nxt;
      if (valid_nxt) begin
        left_pcm  <= DSM_WIDTH'(to_offset_bin(64'(sr_l), DSM_WIDTH));
        right_pcm <= DSM_WIDTH'(to_offset_bin(64'(sr_r), DSM_WIDTH));
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_stereo.sv
// Scoreboard bench for i2s_rx_stereo: frames are pushed as sent and popped
// when sample_valid fires; framing-error and reset behaviour are checked inline.
module tb_i2s_rx_stereo;

  logic        clk = 1'b0;
  logic        aclr;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic [15:0] left_pcm;
  logic [15:0] right_pcm;
  logic        sample_valid;
  logic        frame_err;

  int          n_cmp  = 0;
  int          n_bad  = 0;
  int          n_ferr = 0;
  logic [31:0] sb[$];
  logic [31:0] mon_e;
  logic [15:0] last_l = 16'h8000;
  logic [15:0] last_r = 16'h8000;

  always #5 clk = ~clk;

  i2s_rx_stereo #(.DSM_WIDTH(16), .MAX_SLOT(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .aclr(aclr),
    .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_sdata(sdata),
    .left_pcm(left_pcm), .right_pcm(right_pcm),
    .sample_valid(sample_valid), .frame_err(frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] offs(input logic [31:0] w);
    return {~w[31], w[30:16]};
  endfunction

  // One slot of n BCLK periods (8 clk each); LR and data change on BCLK fall,
  // bit index 0 is the I2S delay bit, MSB appears at index 1.
  task automatic send_slot(input logic lr, input logic [31:0] w, input int n);
    for (int j = 0; j < n; j++) begin
      bclk = 1'b0;
      if (j == 0) lrclk = lr;
      sdata = (j >= 1 && j <= 32) ? w[32-j] : 1'b0;
      repeat (4) @(negedge clk);
      bclk = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input bit push);
    send_slot(1'b0, l, 32);
    send_slot(1'b1, r, 32);
    if (push) sb.push_back({offs(l), offs(r)});
  endtask

  always @(negedge clk) begin
    if (aclr === 1'b1 && sample_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", {31'd0, sample_valid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("left_pcm", {16'd0, left_pcm}, {16'd0, mon_e[31:16]});
        chk("right_pcm", {16'd0, right_pcm}, {16'd0, mon_e[15:0]});
        last_l = mon_e[31:16];
        last_r = mon_e[15:0];
      end
    end
    if (frame_err === 1'b1) n_ferr++;
  end

  initial begin
    aclr  = 1'b0;
    bclk  = 1'b0;
    lrclk = 1'b1;
    sdata = 1'b0;

    // reset state
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset_l", {16'd0, left_pcm}, 32'h8000);
      chk("reset_r", {16'd0, right_pcm}, 32'h8000);
      chk("reset_valid", {31'd0, sample_valid}, 32'd0);
      chk("reset_err", {31'd0, frame_err}, 32'd0);
    end
    aclr = 1'b1;
    repeat (8) @(negedge clk);

    // basic frames and offset conversion extremes
    send_frame(32'h0000_0000, 32'h7FFF_0000, 1'b1);
    send_frame(32'h1234_0000, 32'hFFFF_0000, 1'b1);
    // 24-bit left in a 32-bit slot: low bits truncated
    send_frame(32'h1234_5600, 32'h8000_0000, 1'b1);
    for (int i = 0; i < 2; i++) send_frame($urandom, $urandom, 1'b1);

    // short (10-BCLK) left slot, then resync on the next falling edge
    send_slot(1'b0, 32'hAAAA_0000, 10);
    send_slot(1'b1, 32'h5555_0000, 32);
    chk("short_err_cnt", n_ferr, 32'd1);
    chk("short_hold_l", {16'd0, left_pcm}, {16'd0, last_l});
    chk("short_hold_r", {16'd0, right_pcm}, {16'd0, last_r});
    send_frame(32'h4000_0000, 32'hC000_0000, 1'b1);

    // overlong (40-BCLK) right slot
    send_slot(1'b0, 32'h0F0F_0000, 32);
    send_slot(1'b1, 32'hF0F0_0000, 40);
    chk("long_err_cnt", n_ferr, 32'd2);
    chk("long_hold_l", {16'd0, left_pcm}, {16'd0, last_l});
    chk("long_hold_r", {16'd0, right_pcm}, {16'd0, last_r});
    send_frame(32'h7FFF_0000, 32'h0001_0000, 1'b1);

    // reset pulsed in the middle of a right slot
    send_slot(1'b0, 32'h3333_0000, 32);
    send_slot(1'b1, 32'h6666_0000, 16);
    chk("pre_reset_sb_empty", sb.size(), 32'd0);
    aclr = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_l", {16'd0, left_pcm}, 32'h8000);
    chk("midrst_r", {16'd0, right_pcm}, 32'h8000);
    aclr = 1'b1;
    last_l = 16'h8000;
    last_r = 16'h8000;
    repeat (8) @(negedge clk);
    send_frame(32'hDEAD_0000, 32'hBEEF_0000, 1'b1);
    send_slot(1'b0, 32'h0000_0000, 32);

    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    chk("ferr_total", n_ferr, 32'd2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
